// File: rtl/dp_demux_loader.sv
// Serial-to-parallel loader for the bubble-sort datapath: fills a register bank
// from a valid/ready stream, then takes sorter swap write-backs by slot index.
module dp_demux_loader #(
  parameter int datawidth = 8,
  parameter int depth     = 8,
  parameter int ptrwidth  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [datawidth-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [ptrwidth-1:0]        wr_idx,
  input  logic [datawidth-1:0]       wr_data,
  output logic                       full,
  output logic [ptrwidth:0]          count,
  output logic [depth*datawidth-1:0] bank_out
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ptrwidth-1:0] r_ptr;
  logic [ptrwidth-1:0] w_ptr_next;
  logic                w_accept;
  logic                w_swap;

  assign in_ready = (r_state == ST_LOAD) && !clear;
  assign w_accept = in_ready && in_valid;
  assign w_swap   = (r_state == ST_FULL) && wr_en;
  assign full     = (r_state == ST_FULL);
  assign count    = (r_state == ST_FULL) ? (ptrwidth + 1)'(depth) : {1'b0, r_ptr};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_LOAD: begin
        if (clear) begin
          w_ptr_next = '0;
        end else if (w_accept) begin
          // Last slot filled: pointer wraps so the next load starts at slot 0.
          if (r_ptr == ptrwidth'(depth - 1)) begin
            w_ptr_next   = '0;
            w_state_next = ST_FULL;
          end else begin
            w_ptr_next = r_ptr + ptrwidth'(1);
          end
        end
      end
      ST_FULL: begin
        if (clear) begin
          w_ptr_next   = '0;
          w_state_next = ST_LOAD;
        end
      end
      default: begin
        w_state_next = ST_LOAD;
        w_ptr_next   = '0;
      end
    endcase
  end

  // Indices at or beyond depth match no slot, so out-of-range swaps are dropped.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_slot
      logic [datawidth-1:0] r_slot;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_slot <= '0;
        end else if (w_accept && (r_ptr == ptrwidth'(gi))) begin
          r_slot <= in_data;
        end else if (w_swap && (wr_idx == ptrwidth'(gi))) begin
          r_slot <= wr_data;
        end
      end

      assign bank_out[gi*datawidth +: datawidth] = r_slot;
    end
  endgenerate

endmodule

// File: tb/tb_dp_demux_loader.sv
// Self-checking bench for dp_demux_loader: directed scenarios plus random
// traffic, compared against a slot-array/count model of the loader behaviour.
module tb_dp_demux_loader;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PTRW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DW-1:0]         in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  clear;
  logic                  wr_en;
  logic [PTRW-1:0]       wr_idx;
  logic [DW-1:0]         wr_data;
  logic                  full;
  logic [PTRW:0]         count;
  logic [DEPTH*DW-1:0]   bank_out;

  int total = 0;
  int bad   = 0;

  // Reference model: slot contents, number loaded, and whether the bank is full.
  logic [DW-1:0] m_slot [DEPTH];
  int            m_count;
  bit            m_full;

  always #5 clk = ~clk;

  dp_demux_loader #(.datawidth(DW), .depth(DEPTH), .ptrwidth(PTRW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .full(full), .count(count), .bank_out(bank_out)
  );

  function automatic logic [DEPTH*DW-1:0] exp_bank();
    logic [DEPTH*DW-1:0] b;
    for (int i = 0; i < DEPTH; i++) b[i*DW +: DW] = m_slot[i];
    return b;
  endfunction

  function automatic void model_edge();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
      m_count = 0;
      m_full  = 0;
    end else if (!m_full) begin
      if (clear) begin
        m_count = 0;
      end else if (in_valid) begin
        m_slot[m_count] = in_data;
        m_count++;
        if (m_count == DEPTH) m_full = 1;
      end
    end else begin
      if (wr_en && int'(wr_idx) < DEPTH) m_slot[wr_idx] = wr_data;
      if (clear) begin
        m_full  = 0;
        m_count = 0;
      end
    end
  endfunction

  // One clock: drive inputs, model the edge, land on the following negedge.
  task automatic tick(input bit r, input bit v, input logic [DW-1:0] d, input bit c,
                      input bit we, input logic [PTRW-1:0] idx, input logic [DW-1:0] wd);
    rst = r; in_valid = v; in_data = d; clear = c;
    wr_en = we; wr_idx = idx; wr_data = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    $display("txn rst=%b v=%b d=%h clr=%b we=%b idx=%0d wd=%h -> cnt=%0d full=%b",
             r, v, d, c, we, idx, wd, count, full);
  endtask

  task automatic idle();
    tick(0, 0, '0, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    tick(1, 0, '0, 0, 0, '0, '0);
    tick(1, 1, 8'h33, 0, 1, 4'd2, 8'h44);
    idle();
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (bank_out !== '0) begin bad++; $display("FAIL reset_bank got=%h exp=0", bank_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < DEPTH; k++) begin
      tick(0, 1, DW'(DEPTH - k), 0, 0, '0, '0);
      total++;
      if (count !== (PTRW+1)'(m_count)) begin
        bad++; $display("FAIL fill_count step=%0d got=%0d exp=%0d", k, count, m_count);
      end
    end
    in_valid = 0; #1;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", in_ready); end
    total++; if (bank_out[0 +: DW] !== 8'd8) begin bad++; $display("FAIL fill_slot0 got=%h exp=08", bank_out[0 +: DW]); end
    total++; if (bank_out[7*DW +: DW] !== 8'd1) begin bad++; $display("FAIL fill_slot7 got=%h exp=01", bank_out[7*DW +: DW]); end
    total++; if (bank_out !== exp_bank()) begin bad++; $display("FAIL fill_bank got=%h exp=%h", bank_out, exp_bank()); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 8'hAA, 0, 0, '0, '0);
      total++;
      if (bank_out !== exp_bank() || count !== 5'd8 || in_ready !== 1'b0) begin
        bad++; $display("FAIL backpressure got=%h/%0d/%b exp=%h/8/0", bank_out, count, in_ready, exp_bank());
      end
    end
  endtask

  task automatic test_swap();
    logic [PTRW-1:0] idxs [3];
    logic [DW-1:0]   vals [3];
    idxs = '{4'd0, 4'd7, 4'd9};
    vals = '{8'd1, 8'd8, 8'h3C};
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, '0, 0, 1, idxs[k], vals[k]);
      total++;
      if (bank_out !== exp_bank()) begin
        bad++; $display("FAIL swap idx=%0d got=%h exp=%h", idxs[k], bank_out, exp_bank());
      end
    end
    total++; if (bank_out[0 +: DW] !== 8'd1) begin bad++; $display("FAIL swap_slot0 got=%h exp=01", bank_out[0 +: DW]); end
    total++; if (bank_out[7*DW +: DW] !== 8'd8) begin bad++; $display("FAIL swap_slot7 got=%h exp=08", bank_out[7*DW +: DW]); end
    // Clear and write together: the write lands, then loading restarts.
    tick(0, 0, '0, 1, 1, 4'd3, 8'h77);
    total++;
    if (bank_out !== exp_bank() || count !== 5'd0 || full !== 1'b0) begin
      bad++; $display("FAIL swap_clear got=%h/%0d/%b exp=%h/0/0", bank_out, count, full, exp_bank());
    end
  endtask

  task automatic test_clear_collision();
    for (int k = 0; k < 3; k++) tick(0, 1, DW'(8'h10 + k), 0, 0, '0, '0);
    rst = 0; in_valid = 1; in_data = 8'h55; clear = 1; wr_en = 0; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL clr_ready got=%b exp=0", in_ready); end
    tick(0, 1, 8'h55, 1, 0, '0, '0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", count); end
    total++; if (bank_out[3*DW +: DW] === 8'h55) begin bad++; $display("FAIL clr_slot3 got=%h exp=not 55", bank_out[3*DW +: DW]); end
    tick(0, 1, 8'hC3, 0, 0, '0, '0);
    total++; if (bank_out[0 +: DW] !== 8'hC3 || count !== 5'd1) begin
      bad++; $display("FAIL clr_reload got=%h/%0d exp=c3/1", bank_out[0 +: DW], count);
    end
    total++; if (bank_out !== exp_bank()) begin bad++; $display("FAIL clr_bank got=%h exp=%h", bank_out, exp_bank()); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), DW'($urandom),
           ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 50),
           PTRW'($urandom_range(0, 15)), DW'($urandom));
      total++;
      if (bank_out !== exp_bank() || count !== (PTRW+1)'(m_count) || full !== m_full) begin
        bad++; $display("FAIL random k=%0d got=%h/%0d/%b exp=%h/%0d/%b",
                        k, bank_out, count, full, exp_bank(), m_count, m_full);
      end
      total++;
      if (in_ready !== (!m_full && !clear)) begin
        bad++; $display("FAIL random_ready k=%0d got=%b exp=%b", k, in_ready, !m_full && !clear);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(0, 0, '0, 1, 0, '0, '0);
    for (int k = 0; k < 5; k++) tick(0, 1, DW'($urandom_range(1, 255)), 0, 0, '0, '0);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL mid_pre_count got=%0d exp=5", count); end
    tick(1, 1, 8'h99, 0, 0, '0, '0);
    clear = 0; in_valid = 0; rst = 0; #1;
    total++;
    if (count !== 5'd0 || bank_out !== '0 || full !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_reset got=%0d/%h/%b/%b exp=0/0/0/1", count, bank_out, full, in_ready);
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; clear = 0; wr_en = 0; wr_idx = '0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) m_slot[i] = '0;
    m_count = 0; m_full = 0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_backpressure();
    tick(0, 1, 8'h01, 1, 0, '0, '0);
    for (int k = 0; k < DEPTH; k++) tick(0, 1, DW'(DEPTH - k), 0, 0, '0, '0);
    test_swap();
    test_clear_collision();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
